// File: rtl/rv32i_mc_controller.sv
// Main control FSM of the multicycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback and stalls on mem_ready.
module rv32i_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t state;
    state_t state_next;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_TRAP;
        endcase
    end

    // reset masks every strobe and select in the same cycle it is seen
    always_comb begin
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        if (!reset) begin
            unique case (state)
                S_FETCH: begin
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    pc_update = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc  = 2'b01;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc     = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXECUTER: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                S_EXECUTEI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA    = 2'b10;
                    ALUOp      = 2'b01;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    pc_update = 1'b1;
                end
                S_TRAP:  illegal_instr = 1'b1;
                default: illegal_instr = 1'b0;
            endcase
        end
    end

    assign PCWrite = pc_update | (branch & zero);
    assign state_o = state;

endmodule
